video_write_scheduler: RTL and testbench
========================================

Name: video_write_scheduler

Overview:
- Owns a shadow buffer of displayed digit codes, one per screen position, and tracks which positions are dirty.
- Sequences the video encoder's two-step write protocol for each dirty position: position cycle (addr2=0), then code cycle (addr2=1). It then waits for the downstream pixel consumer to acknowledge.
- Decouples the calculator core, which writes digits at any time without stalling, from encoder/framebuffer timing.
- Sits between the core's display register writes and the video encoder.

Parameters:
- DEPTH, 16, number of screen positions; legal range 2..32; position index width is 5 bits fixed.
- ACK_TIMEOUT, 64, cycles to wait for pix_ack; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_we  in  1  shadow write strobe
- cpu_pos  in  5  shadow write position; writes with cpu_pos >= DEPTH are ignored
- cpu_code  in  5  digit/symbol code to display
- refresh_all  in  1  one-cycle pulse; marks every position dirty
- pix_ack  in  1  downstream consumer has taken the encoder pixel data
- vsel  out  1  encoder select
- addr2  out  1  encoder phase: 0 = position, 1 = code
- vdata  out  5  encoder data_in
- busy  out  1  high in any state other than IDLE
- pending  out  1  OR of all dirty bits
- err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Storage: shadow[DEPTH] x 5 bits, dirty[DEPTH] x 1 bit, scan pointer ptr (5 bits), latched cur_pos and cur_code.
- Reset: shadow, dirty, ptr, cur_pos, cur_code all 0; state IDLE. vsel=0, addr2=0, vdata=0, busy=0, pending=0, err=0.
- Reset mid-sequence abandons the sequence and clears all dirty bits. No encoder write is issued after the reset cycle.
- CPU write at edge E: shadow[cpu_pos] and dirty[cpu_pos] updated at E. The write is never stalled, in any state.
- refresh_all at edge E sets all dirty bits at E. If cpu_we occurs in the same cycle, both take effect.
- States: IDLE, ADDR, DATA, WAIT (plus TOUT with the optional feature).
- IDLE:
  - If any dirty bit is set, select the first dirty position searching from ptr upward, wrapping at DEPTH-1 to 0.
  - Latch cur_pos and cur_code from shadow, clear that dirty bit, go to ADDR.
  - Otherwise stay in IDLE.
- Clear-vs-set collision: if a CPU write to the same position occurs in the selection cycle, its dirty set wins. cur_code takes the old shadow value, and the position is resent later with the new code.
- ADDR (1 cycle): vsel=1, addr2=0, vdata=cur_pos; then go to DATA.
- DATA (1 cycle): vsel=1, addr2=1, vdata=cur_code; then go to WAIT.
- WAIT: vsel=0, addr2=0, vdata=0.
  - On pix_ack=1: ptr = (cur_pos+1) mod DEPTH, go to IDLE.
  - pix_ack in any state other than WAIT is ignored.
- Outputs are registered from the next-state decode, so vsel/addr2/vdata are valid for exactly the cycle the FSM is in ADDR/DATA.
- Minimum cost per position is 4 cycles: IDLE, ADDR, DATA, one WAIT cycle with ack.
- Latency: a CPU write at edge E0 to an idle scheduler gives ADDR in the cycle after edge E0+2 and DATA one cycle later.
- Fairness: round-robin from ptr. A continuously rewritten position cannot starve the others.
- Writes during ADDR/DATA/WAIT update shadow only. The in-flight cur_code is not changed.
- pending is combinational from dirty. busy = (state != IDLE).

Optional Feature:
- Macro: VSCHED_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT. If ACK_TIMEOUT cycles pass without pix_ack, go to TOUT.
  - TOUT (1 cycle): set err (sticky until rst), re-set dirty[cur_pos], ptr = (cur_pos+1) mod DEPTH, go to IDLE.
  - The counter clears on entry to WAIT.
- Disabled: no counter and no TOUT state. WAIT waits indefinitely; err is constant 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no stimulus for 20 cycles -> vsel=0, busy=0, pending=0 throughout.
- Single write: cpu_we with pos=3, code=9; pix_ack returned 2 cycles after DATA -> exactly one ADDR cycle (vdata=3, addr2=0), then one DATA cycle (vdata=9, addr2=1); pending drops in the selection cycle.
- Round-robin: write positions 5, 1, 7 in consecutive cycles, ack immediately in WAIT -> service order 1, 5, 7 (ptr=0); then write pos 0 and pos 6 together with ptr=2 -> order 6, 0.
- Collision: write pos 2 code 4; in its selection cycle write pos 2 code 8 -> first sequence sends code 4, second sends code 8, then pending=0.
- refresh_all with DEPTH=16 and ack always high -> 16 sequences, positions 0..15 in order, 64 cycles total; then busy=0.
- VSCHED_TIMEOUT_EN, ACK_TIMEOUT=4: write pos 9, never ack -> TOUT after 4 WAIT cycles, err=1, pos 9 resent; assert rst mid-DATA -> next cycle vsel=0 and no further sequence.

Source files
------------

// File: rtl/video_write_scheduler.sv
// video_write_scheduler: shadow buffer of displayed digit codes with per-position
// dirty tracking. Dirty positions are replayed to the video encoder as a
// two-step write (position phase, then code phase), one position at a time,
// in round-robin order from the scan pointer.
//
// Optional feature, enabled by defining VSCHED_TIMEOUT_EN: a WAIT-state
// watchdog of ACK_TIMEOUT cycles. On expiry the position is re-queued and the
// sticky err flag is raised. Without the macro, WAIT waits indefinitely and
// err is constant 0.
//
// Encoder handshake: vsel marks an encoder write cycle (addr2=0 carries the
// position, addr2=1 carries the code); pix_ack acts as the ready for the whole
// two-step write and is only sampled in WAIT, where one high cycle completes it.
module video_write_scheduler #(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_we,
  input  logic [4:0] cpu_pos,
  input  logic [4:0] cpu_code,
  input  logic       refresh_all,
  input  logic       pix_ack,
  output logic       vsel,
  output logic       addr2,
  output logic [4:0] vdata,
  output logic       busy,
  output logic       pending,
  output logic       err
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
`ifdef VSCHED_TIMEOUT_EN
    S_WAIT = 3'd3,
    S_TOUT = 3'd4
`else
    S_WAIT = 3'd3
`endif
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [4:0]       shadow [DEPTH];
  logic [DEPTH-1:0] dirty;
  logic [DEPTH-1:0] dirty_next;
  logic [4:0]       ptr;
  logic [4:0]       cur_pos;
  logic [4:0]       cur_code;
  logic             pending_q;
  logic             found;
  logic [4:0]       sel_pos;
  logic [5:0]       idx;
  logic             take;
  logic             cpu_hit;
  logic [5:0]       pos_inc;
  logic [4:0]       ptr_after;
  logic             vsel_d;
  logic             addr2_d;
  logic [4:0]       vdata_d;

  assign pending   = |dirty;
  assign busy      = (state != S_IDLE);
  assign cpu_hit   = cpu_we && (32'(cpu_pos) < DEPTH);
  assign pos_inc   = {1'b0, cur_pos} + 6'd1;
  assign ptr_after = (32'(pos_inc) >= DEPTH) ? 5'd0 : pos_inc[4:0];

  // Selection is gated by last cycle's pending so that writes landing in
  // back-to-back cycles are arbitrated together rather than first-come.
  assign take = (state == S_IDLE) && pending_q && found;

`ifdef VSCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          tcnt_done;
  logic          err_q;

  assign tcnt_done = (32'(tcnt) == ACK_TIMEOUT - 1);
  assign err       = err_q;

  // WAIT watchdog: held at zero outside WAIT, so it restarts on every entry
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) tcnt <= '0;
    else                        tcnt <= tcnt + TW'(1);
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (state == S_TOUT) err_q <= 1'b1;
  end
`else
  localparam int unused_ack_timeout = ACK_TIMEOUT;
  assign err = 1'b0;
`endif

  // Round-robin search: first dirty position at or after ptr, wrapping at DEPTH-1
  always_comb begin
    found   = 1'b0;
    sel_pos = '0;
    idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 6'(i);
      if (32'(idx) >= DEPTH) idx = idx - 6'(DEPTH);
      if (dirty[idx[AW-1:0]]) begin
        found   = 1'b1;
        sel_pos = idx[4:0];
      end
    end
  end

  // Dirty update: the CPU set is applied last so it wins over a same-cycle clear
  always_comb begin
    dirty_next = dirty;
    if (take) dirty_next[sel_pos[AW-1:0]] = 1'b0;
`ifdef VSCHED_TIMEOUT_EN
    if (state == S_TOUT) dirty_next[cur_pos[AW-1:0]] = 1'b1;
`endif
    if (refresh_all) dirty_next = '1;
    if (cpu_hit) dirty_next[cpu_pos[AW-1:0]] = 1'b1;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (take) state_next = S_ADDR;
      S_ADDR: state_next = S_DATA;
      S_DATA: state_next = S_WAIT;
      S_WAIT: begin
        if (pix_ack) state_next = S_IDLE;
`ifdef VSCHED_TIMEOUT_EN
        else if (tcnt_done) state_next = S_TOUT;
`endif
      end
`ifdef VSCHED_TIMEOUT_EN
      S_TOUT: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Encoder outputs decoded from the next state; ADDR takes the position being
  // latched this cycle, since cur_pos only updates on the same edge
  always_comb begin
    vsel_d  = 1'b0;
    addr2_d = 1'b0;
    vdata_d = '0;
    case (state_next)
      S_ADDR: begin
        vsel_d  = 1'b1;
        vdata_d = sel_pos;
      end
      S_DATA: begin
        vsel_d  = 1'b1;
        addr2_d = 1'b1;
        vdata_d = cur_code;
      end
      default: ;
    endcase
  end

  // State register and registered encoder outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      vsel  <= 1'b0;
      addr2 <= 1'b0;
      vdata <= '0;
    end else begin
      state <= state_next;
      vsel  <= vsel_d;
      addr2 <= addr2_d;
      vdata <= vdata_d;
    end
  end

  // Shadow buffer, dirty bits, scan pointer and the in-flight position/code
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
      dirty     <= '0;
      ptr       <= '0;
      cur_pos   <= '0;
      cur_code  <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending;
      dirty     <= dirty_next;
      if (cpu_hit) shadow[cpu_pos[AW-1:0]] <= cpu_code;
      if (take) begin
        cur_pos  <= sel_pos;
        cur_code <= shadow[sel_pos[AW-1:0]];
      end
      if (state == S_WAIT && pix_ack) ptr <= ptr_after;
`ifdef VSCHED_TIMEOUT_EN
      if (state == S_TOUT) ptr <= ptr_after;
`endif
    end
  end

endmodule

// File: tb/tb_video_write_scheduler.sv
// Testbench for video_write_scheduler: directed scenarios plus randomized
// write bursts, checked against a round-robin model of the dirty set.
module tb_video_write_scheduler;

  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_we;
  logic [4:0] cpu_pos;
  logic [4:0] cpu_code;
  logic       refresh_all;
  logic       pix_ack;
  logic       vsel;
  logic       addr2;
  logic [4:0] vdata;
  logic       busy;
  logic       pending;
  logic       err;

  always #5 clk = ~clk;

  video_write_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_pos(cpu_pos),
    .cpu_code(cpu_code), .refresh_all(refresh_all), .pix_ack(pix_ack),
    .vsel(vsel), .addr2(addr2), .vdata(vdata), .busy(busy),
    .pending(pending), .err(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int         addr_cyc_q[$];
  logic       pend_at_addr_q[$];
  int         proto_err = 0;
  int         last_wr_cyc = 0;

  // Encoder monitor: pairs each position cycle with the code cycle after it
  logic       prev_addr = 1'b0;
  logic [4:0] addr_val  = '0;
  always @(negedge clk) begin
    if (vsel && !busy) proto_err++;
    if (vsel && !addr2) begin
      addr_val = vdata;
      addr_cyc_q.push_back(cyc);
      pend_at_addr_q.push_back(pending);
    end
    if (vsel && addr2) begin
      if (!prev_addr) proto_err++;
      obs_q.push_back({addr_val, vdata});
    end else if (prev_addr) begin
      proto_err++;
    end
    prev_addr = vsel && !addr2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [4:0] m_shadow [DEPTH];
  bit         m_dirty  [DEPTH];
  int         m_ptr;

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic m_write(input int pos, input int code);
    if (pos < DEPTH) begin
      m_shadow[pos] = 5'(code);
      m_dirty[pos]  = 1'b1;
    end
  endtask

  // Service the first dirty position from the pointer onward
  task automatic m_take_one();
    for (int k = 0; k < DEPTH; k++) begin
      int p;
      p = (m_ptr + k) % DEPTH;
      if (m_dirty[p]) begin
        exp_q.push_back({5'(p), m_shadow[p]});
        m_dirty[p] = 1'b0;
        m_ptr = (p + 1) % DEPTH;
        break;
      end
    end
  endtask

  task automatic m_drain();
    for (int n = 0; n < DEPTH; n++) m_take_one();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int pos, input int code);
    cpu_we   = 1'b1;
    cpu_pos  = 5'(pos);
    cpu_code = 5'(code);
    @(negedge clk);
    cpu_we = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic wait_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && !vsel) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_data(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (vsel && addr2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Acknowledge n encoder writes, each after dmin..dmax extra WAIT cycles
  task automatic serve(input int n, input int dmin, input int dmax);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_wait(ok);
      if (!ok) begin
        check("serve_reach_wait", 32'(ok), 32'd1);
        return;
      end
      repeat ($urandom_range(dmax, dmin)) @(negedge clk);
      pix_ack = 1'b1;
      @(negedge clk);
      pix_ack = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    addr_cyc_q.delete();
    pend_at_addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit ok;
    int quiet;
    int r_cyc;
    int t_idle;
    int c1, c2, c3;

    rst = 1'b1; cpu_we = 1'b0; cpu_pos = '0; cpu_code = '0;
    refresh_all = 1'b0; pix_ack = 1'b0;
    m_reset();
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then a quiet idle stretch
    check("rst_vsel", 32'(vsel), 0);
    check("rst_addr2", 32'(addr2), 0);
    check("rst_vdata", 32'(vdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_err", 32'(err), 0);
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (vsel || busy || pending) quiet++;
    end
    check("idle_quiet", 32'(quiet), 0);

    // Single write, ack two cycles after DATA
    wr(3, 9);
    m_write(3, 9);
    m_drain();
    check("single_pending_set", 32'(pending), 1);
    serve(1, 1, 1);
    check("single_latency", 32'(addr_cyc_q.size() > 0 ? addr_cyc_q[0] - last_wr_cyc : -1), 2);
    check("single_pending_drop", 32'(pend_at_addr_q.size() > 0 ? pend_at_addr_q[0] : 1'b1), 0);
    compare_all("single");
    check("single_busy_after", 32'(busy), 0);

    // Round-robin from ptr=0: writes 5,1,7 in consecutive cycles
    do_reset();
    c1 = $urandom_range(31, 0); c2 = $urandom_range(31, 0); c3 = $urandom_range(31, 0);
    wr(5, c1); wr(1, c2); wr(7, c3);
    m_write(5, c1); m_write(1, c2); m_write(7, c3);
    m_drain();
    serve(3, 0, 0);
    check("rr_spacing", 32'(addr_cyc_q.size() > 1 ? addr_cyc_q[1] - addr_cyc_q[0] : -1), 4);
    compare_all("rr_157");

    // Bring ptr to 2, then 0 and 6 back to back -> 6 before 0
    wr(1, 17); m_write(1, 17); m_drain();
    serve(1, 0, 0);
    compare_all("rr_ptr2");
    c1 = $urandom_range(31, 0); c2 = $urandom_range(31, 0);
    wr(0, c1); wr(6, c2);
    m_write(0, c1); m_write(6, c2);
    m_drain();
    serve(2, 0, 0);
    compare_all("rr_60");

    // Collision: rewrite pos 2 in its own selection cycle
    wr(2, 4);
    @(negedge clk);
    wr(2, 8);
    m_write(2, 4); m_take_one(); m_write(2, 8); m_drain();
    serve(2, 0, 1);
    compare_all("collision");
    check("collision_pending", 32'(pending), 0);

    // refresh_all after reset with ack always high
    do_reset();
    pix_ack = 1'b1;
    refresh_all = 1'b1;
    @(negedge clk);
    refresh_all = 1'b0;
    r_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) m_dirty[i] = 1'b1;
    m_drain();
    for (int i = 0; i < 400 && obs_q.size() < DEPTH; i++) @(negedge clk);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    t_idle = cyc;
    pix_ack = 1'b0;
    check("refresh_total_cycles", 32'(t_idle - (r_cyc + 1)), 64);
    check("refresh_addr_span", 32'(addr_cyc_q.size() == DEPTH ? addr_cyc_q[DEPTH-1] - addr_cyc_q[0] : -1), 60);
    check("refresh_busy_after", 32'(busy), 0);
    compare_all("refresh");

`ifndef VSCHED_TIMEOUT_EN
    // Random bursts of writes while a write is held in WAIT
    for (int r = 0; r < 4; r++) begin
      int p0;
      int nb;
      p0 = $urandom_range(DEPTH - 1, 0);
      c1 = $urandom_range(31, 0);
      wr(p0, c1);
      m_write(p0, c1);
      m_take_one();
      wait_wait(ok);
      check("rand_reach_wait", 32'(ok), 1);
      nb = $urandom_range(20, 4);
      for (int i = 0; i < nb; i++) begin
        int pos;
        int code;
        pos  = $urandom_range(31, 0);
        code = $urandom_range(31, 0);
        wr(pos, code);
        m_write(pos, code);
        if ($urandom_range(1, 0) == 1) @(negedge clk);
      end
      pix_ack = 1'b1;
      @(negedge clk);
      pix_ack = 1'b0;
      m_drain();
      serve(exp_q.size() - 1, 0, 3);
      compare_all("rand_burst");
      check("rand_pending_after", 32'(pending), 0);
    end
`endif

    // Reset in the middle of a DATA cycle with another position dirty
    wr(9, 5); wr(12, 3);
    wait_data(ok);
    check("midrst_reach_data", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check("midrst_vsel", 32'(vsel), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pending", 32'(pending), 0);
    obs_q.delete(); addr_cyc_q.delete(); pend_at_addr_q.delete();
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (vsel || busy) quiet++;
    end
    check("midrst_quiet", 32'(quiet), 0);

`ifdef VSCHED_TIMEOUT_EN
    // Timeout: no ack, TOUT after ACK_TIMEOUT WAIT cycles, position resent
    begin
      int nbusy;
      wr(9, 7);
      m_write(9, 7); m_take_one(); m_dirty[9] = 1'b1; m_take_one();
      wait_data(ok);
      check("tout_reach_data", 32'(ok), 1);
      nbusy = 0;
      @(negedge clk);
      while (busy && nbusy < 20) begin
        nbusy++;
        @(negedge clk);
      end
      check("tout_wait_plus_tout", 32'(nbusy), ACK_TIMEOUT + 1);
      check("tout_err", 32'(err), 1);
      wait_data(ok);
      check("tout_resend_data", 32'(ok), 1);
      compare_all("tout_resend");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      check("tout_rst_vsel", 32'(vsel), 0);
      check("tout_rst_err", 32'(err), 0);
      quiet = 0;
      repeat (12) begin
        @(negedge clk);
        if (vsel || busy) quiet++;
      end
      check("tout_rst_quiet", 32'(quiet), 0);
      obs_q.delete(); addr_cyc_q.delete(); pend_at_addr_q.delete();
    end
`else
    check("err_tied_low", 32'(err), 0);
`endif

    check("protocol", 32'(proto_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
